bit_stuffer: RTL and testbench
==============================

Name: bit_stuffer

Overview:
Transmit-side USB bit stuffer. It takes the serial packet bit stream ahead of the NRZI encoder and inserts a 0 after every RUN_LEN consecutive 1s. It stalls the upstream serializer through a ready signal for each inserted bit. It sits between the packet serializer and the NRZI encoder, and its output stream is exactly what the receive-side unstuffer strips.

Parameters:
RUN_LEN, 6, number of consecutive 1s that triggers insertion of one 0 bit.
CNT_W, $clog2(RUN_LEN+1), width of the ones-run counter (derived; not overridden).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_b  input  1  reset, synchronous, active-low
bstr_in  input  1  unstuffed data bit from serializer
bstr_in_avail  input  1  bstr_in valid this cycle
in_done  input  1  end-of-packet marker from serializer
bstr_in_ready  output  1  block accepts bstr_in / in_done this cycle
bstr_out  output  1  stuffed data bit to NRZI encoder
bstr_out_avail  output  1  bstr_out valid this cycle
out_done  output  1  end-of-packet marker, one-cycle pulse

Behaviour:
- Reset: when rst_b is low at a rising edge, set state=PASS, cnt=0, done_pend=0, bstr_out=0, bstr_out_avail=0, out_done=0. bstr_in_ready is 0 whenever rst_b is low. Reset mid-packet abandons the packet; no stuff bit and no out_done are emitted for it.
- Accept rules: a bit is accepted on an edge where bstr_in_avail && bstr_in_ready. in_done is accepted on an edge where in_done && bstr_in_ready. While bstr_in_ready is 0, upstream holds bstr_in, bstr_in_avail and in_done stable.
- bstr_in_ready = rst_b && state==PASS && !done_pend.
- Latency: 1 cycle. An accepted bit appears on bstr_out with bstr_out_avail=1 in the next cycle. On any cycle with no output, bstr_out_avail=0 and bstr_out=0.
- Counter:
  - Accepted 1: cnt <= cnt+1.
  - Accepted 0: cnt <= 0.
  - No accept: cnt holds. Idle gaps mid-packet do not break a run.
  - Emitting a stuff bit: cnt <= 0.
  - Accepted in_done: cnt <= 0 after any pending stuff is emitted.
  - cnt never exceeds RUN_LEN.
- FSM states:
  - PASS: normal pass-through. If the accepted bit is a 1 and cnt==RUN_LEN-1, next state is STUFF; otherwise stay in PASS.
  - STUFF: bstr_in_ready=0. At the edge, drive bstr_out=0 and bstr_out_avail=1 for the next cycle, set cnt=0, and go to PASS.
  - Net effect: ready is low for exactly one cycle, namely the cycle after the RUN_LEN-th 1 is accepted.
- End of packet:
  - in_done accepted alone (bstr_in_avail=0): out_done=1 in the next cycle, with bstr_out_avail=0.
  - in_done accepted together with a bit: the bit is emitted normally, then any required stuff bit, then out_done on the following cycle with bstr_out_avail=0. done_pend holds the done across a STUFF cycle.
  - out_done is never coincident with bstr_out_avail.
  - After out_done, cnt=0 and state=PASS. Back-to-back packets are allowed the cycle after out_done.
- Width rules: cnt compares against RUN_LEN-1 at CNT_W width; no wrap is reachable.

Decomposition:
- Package usb_pkg holds:
  - typedef enum logic {PASS, STUFF} stuff_state_t
  - localparam USB_STUFF_RUN = 6
- Sub-module bit_stuffer_ctrl contains the FSM, cnt and done_pend, and produces bstr_in_ready, a stuff-insert strobe and a done-emit strobe.
- The top bit_stuffer contains the output register mux (data bit, stuff 0, or done).

Test Plan:
1. Stream 0,1,0,1,0,1,0,1 with avail=1 every cycle, then in_done alone -> identical bits on bstr_out 1 cycle later, bstr_in_ready constantly 1, out_done 1 cycle after in_done.
2. Seven 1s then 0 -> bstr_out = 1,1,1,1,1,1,0,1,0; bstr_in_ready=0 for exactly one cycle (the cycle after the 6th 1 is accepted); the 7th 1 is held and accepted the following cycle.
3. Twelve consecutive 1s -> 1×6,0,1×6,0; ready drops twice; 14 output bits in total.
4. Six 1s with in_done asserted alongside the 6th -> bstr_out = 1×6 then 0, then out_done=1 with bstr_out_avail=0 on the next cycle; ready stays 0 until after the stuff bit.
5. 1,1,1, three idle cycles (avail=0), 1,1,1,1 -> stuff 0 inserted after the 6th 1 despite the gap; output 1×6,0,1.
6. Five 1s, rst_b=0 for one edge, release, then five 1s -> all outputs 0 the cycle after the reset edge; no stuff bit in the second run (cnt cleared); ready=0 only while rst_b is low.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB transmit-path types and constants.
package usb_pkg;

   typedef enum logic {PASS, STUFF} stuff_state_t;

   localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/bit_stuffer_if.sv
// Serial bit-stream link between the packet serializer, the bit stuffer and the NRZI encoder.
interface bit_stuffer_if;

   logic bstr_in;
   logic bstr_in_avail;
   logic in_done;
   logic bstr_in_ready;
   logic bstr_out;
   logic bstr_out_avail;
   logic out_done;

   // The serializer/encoder side of the link.
   modport master (
      output bstr_in, bstr_in_avail, in_done,
      input  bstr_in_ready, bstr_out, bstr_out_avail, out_done
   );

   // The stuffer side of the link.
   modport slave (
      input  bstr_in, bstr_in_avail, in_done,
      output bstr_in_ready, bstr_out, bstr_out_avail, out_done
   );

endinterface

// File: rtl/bit_stuffer_ctrl.sv
// Stuffing control: ones-run counter, PASS/STUFF FSM and end-of-packet pending flag.
module bit_stuffer_ctrl
   import usb_pkg::*;
#(
   parameter int RUN_LEN = USB_STUFF_RUN
) (
   input  logic clk,
   input  logic rst_b,
   input  logic in_bit,
   input  logic in_bit_avail,
   input  logic in_done,
   output logic in_ready,
   output logic bit_accept,
   output logic stuff_emit,
   output logic done_emit
);

   localparam int CNT_W = $clog2(RUN_LEN + 1);

   stuff_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_pend_q, done_pend_d;
   logic             done_accept;

   assign in_ready    = rst_b && (state_q == PASS) && !done_pend_q;
   assign bit_accept  = in_bit_avail && in_ready;
   assign done_accept = in_done && in_ready;
   assign stuff_emit  = (state_q == STUFF);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      done_pend_d = done_pend_q;
      done_emit   = 1'b0;
      case (state_q)
         STUFF: begin
            state_d = PASS;
            cnt_d   = '0;
         end
         PASS: begin
            if (done_pend_q) begin
               // Deferred end-of-packet: the last data (and stuff) bit has already gone out.
               done_emit   = 1'b1;
               done_pend_d = 1'b0;
               cnt_d       = '0;
            end else begin
               if (bit_accept) begin
                  if (in_bit) begin
                     cnt_d = cnt_q + CNT_W'(1);
                     if (cnt_q == CNT_W'(RUN_LEN - 1)) state_d = STUFF;
                  end else begin
                     cnt_d = '0;
                  end
               end
               if (done_accept) begin
                  if (bit_accept) begin
                     done_pend_d = 1'b1;
                  end else begin
                     done_emit = 1'b1;
                     cnt_d     = '0;
                  end
               end
            end
         end
         default: state_d = PASS;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_b) begin
         state_q     <= PASS;
         cnt_q       <= '0;
         done_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         done_pend_q <= done_pend_d;
      end
   end

endmodule

// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every RUN_LEN consecutive 1s, one-cycle latency.
module bit_stuffer
   import usb_pkg::*;
#(
   parameter int RUN_LEN = USB_STUFF_RUN
) (
   input  logic          clk,
   input  logic          rst_b,
   bit_stuffer_if.slave  bus
);

   logic bit_accept;
   logic stuff_emit;
   logic done_emit;
   logic out_bit_q;
   logic out_avail_q;
   logic out_done_q;

   bit_stuffer_ctrl #(
      .RUN_LEN (RUN_LEN)
   ) u_ctrl (
      .clk          (clk),
      .rst_b        (rst_b),
      .in_bit       (bus.bstr_in),
      .in_bit_avail (bus.bstr_in_avail),
      .in_done      (bus.in_done),
      .in_ready     (bus.bstr_in_ready),
      .bit_accept   (bit_accept),
      .stuff_emit   (stuff_emit),
      .done_emit    (done_emit)
   );

   // The three sources are mutually exclusive: ready is low in STUFF and while a done is pending.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         out_bit_q   <= 1'b0;
         out_avail_q <= 1'b0;
         out_done_q  <= 1'b0;
      end else begin
         out_bit_q   <= 1'b0;
         out_avail_q <= 1'b0;
         out_done_q  <= 1'b0;
         if (stuff_emit) begin
            out_avail_q <= 1'b1;
         end else if (bit_accept) begin
            out_bit_q   <= bus.bstr_in;
            out_avail_q <= 1'b1;
         end else if (done_emit) begin
            out_done_q  <= 1'b1;
         end
      end
   end

   assign bus.bstr_out       = out_bit_q;
   assign bus.bstr_out_avail = out_avail_q;
   assign bus.out_done       = out_done_q;

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed, table-driven bench for bit_stuffer with hand-computed per-cycle expectations.
module tb_bit_stuffer;

   typedef struct {
      logic rst_b;
      logic avail;
      logic bt;
      logic done;
      logic exp_rdy;
      logic exp_oav;
      logic exp_out;
      logic exp_od;
   } vec_t;

   logic clk;
   logic rst_b;
   int   n_cmp;
   int   n_bad;
   vec_t vecs[$];

   bit_stuffer_if bus ();

   bit_stuffer dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after a falling edge, then let them settle.
   task automatic drive(input logic r, input logic av, input logic b, input logic dn);
      rst_b             = r;
      bus.bstr_in_avail = av;
      bus.bstr_in       = b;
      bus.in_done       = dn;
      #1;
   endtask

   function automatic void push(input logic r, input logic av, input logic b, input logic dn,
                                input logic rdy, input logic oav, input logic ob, input logic od);
      vecs.push_back('{r, av, b, dn, rdy, oav, ob, od});
   endfunction

   function automatic logic [3:0] outs();
      return {1'b0, bus.bstr_out_avail, bus.bstr_out, bus.out_done};
   endfunction

   initial begin
      int lat;
      n_cmp = 0;
      n_bad = 0;

      // Row fields: rst_b, avail, bit, done | ready, out_avail, out_bit, out_done (outputs of the previous edge).
      // Alternating pattern, then done alone.
      for (int i = 0; i < 8; i++) push(1, 1, 1'(i % 2), 0, 1, (i > 0), 1'((i + 1) % 2) & (i > 0), 0);
      push(1, 0, 0, 1, 1, 1, 1, 0);
      push(1, 0, 0, 0, 1, 0, 0, 1);
      push(1, 0, 0, 0, 1, 0, 0, 0);
      // Seven 1s then 0: 7th 1 held across the single stall cycle.
      push(1, 1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) push(1, 1, 1, 0, 1, 1, 1, 0);
      push(1, 1, 1, 0, 0, 1, 1, 0);
      push(1, 1, 1, 0, 1, 1, 0, 0);
      push(1, 1, 0, 0, 1, 1, 1, 0);
      push(1, 0, 0, 0, 1, 1, 0, 0);
      push(1, 0, 0, 0, 1, 0, 0, 0);
      // Twelve 1s: two stuff bits, fourteen output bits.
      push(1, 1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) push(1, 1, 1, 0, 1, 1, 1, 0);
      push(1, 1, 1, 0, 0, 1, 1, 0);
      push(1, 1, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) push(1, 1, 1, 0, 1, 1, 1, 0);
      push(1, 0, 0, 0, 0, 1, 1, 0);
      push(1, 0, 0, 0, 1, 1, 0, 0);
      push(1, 0, 0, 0, 1, 0, 0, 0);
      // Six 1s with in_done on the 6th: bit, stuff, then done.
      push(1, 1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) push(1, 1, 1, 0, 1, 1, 1, 0);
      push(1, 1, 1, 1, 1, 1, 1, 0);
      push(1, 0, 0, 0, 0, 1, 1, 0);
      push(1, 0, 0, 0, 0, 1, 0, 0);
      push(1, 0, 0, 0, 1, 0, 0, 1);
      push(1, 0, 0, 0, 1, 0, 0, 0);
      // A 0 with in_done and no stuff: done one cycle after the bit.
      push(1, 1, 0, 1, 1, 0, 0, 0);
      push(1, 0, 0, 0, 0, 1, 0, 0);
      push(1, 0, 0, 0, 1, 0, 0, 1);
      push(1, 0, 0, 0, 1, 0, 0, 0);
      // 1,1,1, three idle cycles, 1,1,1,1 then a 0: the gap does not break the run.
      push(1, 1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) push(1, 1, 1, 0, 1, 1, 1, 0);
      push(1, 0, 0, 0, 1, 1, 1, 0);
      for (int i = 0; i < 2; i++) push(1, 0, 0, 0, 1, 0, 0, 0);
      push(1, 1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) push(1, 1, 1, 0, 1, 1, 1, 0);
      push(1, 1, 1, 0, 0, 1, 1, 0);
      push(1, 1, 1, 0, 1, 1, 0, 0);
      push(1, 1, 0, 0, 1, 1, 1, 0);
      push(1, 0, 0, 0, 1, 1, 0, 0);
      push(1, 0, 0, 0, 1, 0, 0, 0);
      // Five 1s, one reset edge, five more 1s: no stuff in the second run.
      push(1, 1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) push(1, 1, 1, 0, 1, 1, 1, 0);
      push(0, 1, 1, 0, 0, 1, 1, 0);
      push(1, 0, 0, 0, 1, 0, 0, 0);
      push(1, 1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) push(1, 1, 1, 0, 1, 1, 1, 0);
      push(1, 0, 0, 0, 1, 1, 1, 0);
      push(1, 0, 0, 0, 1, 0, 0, 0);
      push(1, 1, 0, 0, 1, 0, 0, 0);
      push(1, 0, 0, 0, 1, 1, 0, 0);

      // Reset state.
      drive(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_ready", 0, {3'b0, bus.bstr_in_ready}, 4'b0000);
      check("reset_outs", 0, outs(), 4'b0000);

      foreach (vecs[i]) begin
         drive(vecs[i].rst_b, vecs[i].avail, vecs[i].bt, vecs[i].done);
         check("vec_ready", i, {3'b0, bus.bstr_in_ready}, {3'b0, vecs[i].exp_rdy});
         check("vec_outs", i, outs(), {1'b0, vecs[i].exp_oav, vecs[i].exp_out, vecs[i].exp_od});
         @(negedge clk);
      end

      // in_done alone: bounded wait for out_done, expected exactly one cycle later.
      drive(1, 0, 0, 1);
      check("done_alone_ready", 0, {3'b0, bus.bstr_in_ready}, 4'b0001);
      @(negedge clk);
      drive(1, 0, 0, 0);
      lat = 99;
      for (int c = 1; c <= 4; c++) begin
         if (bus.out_done === 1'b1 && lat == 99) begin
            lat = c;
            check("done_alone_avail", 0, {3'b0, bus.bstr_out_avail}, 4'b0000);
         end
         @(negedge clk);
         #1;
      end
      check("done_alone_latency", 0, 4'(lat), 4'd1);

      // Reset while a stuff bit is due: the stuff bit is dropped.
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 1, 0);
         check("stuff_rst_run_ready", i, {3'b0, bus.bstr_in_ready}, 4'b0001);
         @(negedge clk);
      end
      drive(0, 0, 0, 0);
      check("stuff_rst_ready", 0, {3'b0, bus.bstr_in_ready}, 4'b0000);
      check("stuff_rst_last_bit", 0, outs(), 4'b0110);
      @(negedge clk);
      drive(1, 0, 0, 0);
      check("stuff_rst_ready", 1, {3'b0, bus.bstr_in_ready}, 4'b0001);
      check("stuff_rst_outs", 0, outs(), 4'b0000);
      @(negedge clk);
      #1;
      check("stuff_rst_outs", 1, outs(), 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
